speicher_arbiter: RTL

Two-port arbiter and sequencer that shares one word-addressed RAM between the instruction cache (port 0) and the data cache (port 1). It sits between the caches' RAM-side interfaces and a single RAM instance. It accepts one transaction at a time, latches the winning requester's command, drives the RAM strobes until the RAM acknowledges, then returns a one-cycle completion pulse and the read data to the winner.

---
 rtl/speicher_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/speicher_arbiter.sv
// Shares one word-addressed RAM between the instruction cache (port 0) and data cache (port 1).
// Optional round-robin tie breaking: define SPEICHER_ARBITER_ROUNDROBIN_EN (default: port 1 wins ties).
module speicher_arbiter #(
  parameter int ADRESSBREITE = 32,
  parameter int DATENBREITE  = 32
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Lesen0,
  input  logic                    Lesen1,
  input  logic                    Schreiben0,
  input  logic                    Schreiben1,
  input  logic [ADRESSBREITE-1:0] Adresse0,
  input  logic [ADRESSBREITE-1:0] Adresse1,
  input  logic [DATENBREITE-1:0]  SchreibDaten0,
  input  logic [DATENBREITE-1:0]  SchreibDaten1,
  output logic [DATENBREITE-1:0]  LesDaten0,
  output logic [DATENBREITE-1:0]  LesDaten1,
  output logic                    DatenGelesen0,
  output logic                    DatenGelesen1,
  output logic                    DatenGeschrieben0,
  output logic                    DatenGeschrieben1,
  output logic                    RAMLesen,
  output logic                    RAMSchreiben,
  output logic [ADRESSBREITE-1:0] RAMAdresse,
  output logic [DATENBREITE-1:0]  RAMSchreibDaten,
  input  logic [DATENBREITE-1:0]  RAMLesDaten,
  input  logic                    RAMDatenGelesen,
  input  logic                    RAMDatenGeschrieben
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} zustandT;

  zustandT zustand;
  logic    vergabe;
  logic    schreibOp;
`ifdef SPEICHER_ARBITER_ROUNDROBIN_EN
  logic    letzteVergabe;
`endif

  logic [1:0]              lesenVec;
  logic [1:0]              schreibenVec;
  logic [1:0]              anfrageVec;
  logic                    gewinner;
  logic                    gewinnerSchreibt;
  logic [ADRESSBREITE-1:0] gewinnerAdresse;
  logic [DATENBREITE-1:0]  gewinnerDaten;

  assign lesenVec     = {Lesen1, Lesen0};
  assign schreibenVec = {Schreiben1, Schreiben0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gAnfrage
      assign anfrageVec[gi] = lesenVec[gi] | schreibenVec[gi];
    end
  endgenerate

  always_comb begin
    gewinner = anfrageVec[1];
    if (anfrageVec == 2'b11) begin
`ifdef SPEICHER_ARBITER_ROUNDROBIN_EN
      gewinner = ~letzteVergabe;
`else
      gewinner = 1'b1;
`endif
    end
  end

  // A port asserting both read and write is treated as a write.
  assign gewinnerSchreibt = gewinner ? Schreiben1 : Schreiben0;
  assign gewinnerAdresse  = gewinner ? Adresse1 : Adresse0;
  assign gewinnerDaten    = gewinner ? SchreibDaten1 : SchreibDaten0;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand           <= IDLE;
      vergabe           <= 1'b0;
      schreibOp         <= 1'b0;
`ifdef SPEICHER_ARBITER_ROUNDROBIN_EN
      letzteVergabe     <= 1'b1;
`endif
      RAMLesen          <= 1'b0;
      RAMSchreiben      <= 1'b0;
      RAMAdresse        <= '0;
      RAMSchreibDaten   <= '0;
      LesDaten0         <= '0;
      LesDaten1         <= '0;
      DatenGelesen0     <= 1'b0;
      DatenGelesen1     <= 1'b0;
      DatenGeschrieben0 <= 1'b0;
      DatenGeschrieben1 <= 1'b0;
    end else begin
      DatenGelesen0     <= 1'b0;
      DatenGelesen1     <= 1'b0;
      DatenGeschrieben0 <= 1'b0;
      DatenGeschrieben1 <= 1'b0;
      case (zustand)
        IDLE: begin
          if (|anfrageVec) begin
            vergabe         <= gewinner;
            schreibOp       <= gewinnerSchreibt;
            RAMAdresse      <= gewinnerAdresse;
            RAMSchreibDaten <= gewinnerDaten;
            RAMSchreiben    <= gewinnerSchreibt;
            RAMLesen        <= ~gewinnerSchreibt;
            zustand         <= ISSUE;
          end
        end
        ISSUE: begin
          // Only the acknowledge matching the latched op ends the access.
          if (schreibOp && RAMDatenGeschrieben) begin
            RAMSchreiben <= 1'b0;
            zustand      <= DONE;
            if (vergabe) DatenGeschrieben1 <= 1'b1;
            else         DatenGeschrieben0 <= 1'b1;
          end else if (!schreibOp && RAMDatenGelesen) begin
            RAMLesen <= 1'b0;
            zustand  <= DONE;
            if (vergabe) begin
              LesDaten1     <= RAMLesDaten;
              DatenGelesen1 <= 1'b1;
            end else begin
              LesDaten0     <= RAMLesDaten;
              DatenGelesen0 <= 1'b1;
            end
          end
        end
        DONE: begin
`ifdef SPEICHER_ARBITER_ROUNDROBIN_EN
          letzteVergabe <= vergabe;
`endif
          zustand <= IDLE;
        end
        default: zustand <= IDLE;
      endcase
    end
  end

endmodule
